// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB/multi-channel PWM LED controller:
// command byte values and the parser state encoding.
package rgb_pkg;

    // Command bytes (ASCII) decoded while the parser is idle
    localparam logic [7:0] CMD_R      = 8'd82;  // 'R' toggle channel 0
    localparam logic [7:0] CMD_G      = 8'd71;  // 'G' toggle channel 1
    localparam logic [7:0] CMD_B      = 8'd66;  // 'B' toggle channel 2
    localparam logic [7:0] CMD_K      = 8'd75;  // 'K' all channels off
    localparam logic [7:0] CMD_A      = 8'd65;  // 'A' all channels on
    localparam logic [7:0] CMD_M      = 8'd77;  // 'M' toggle blink mode
    localparam logic [7:0] CMD_L      = 8'd76;  // 'L' start duty-level sequence
    localparam logic [7:0] CMD_DIGIT0 = 8'd48;  // '0' base of channel digits

    // Parser states
    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_CH   = 2'd1;
    localparam logic [1:0] P_VAL  = 2'd2;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: compares the shared counter against this channel's duty
// and registers the resulting "lit" state, gated by the channel enable.
module pwm_channel
    import rgb_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                srst,
    input  logic [PWM_BITS-1:0] counter,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                enable,
    output logic                lit
);

    // All-ones duty means continuously on, so the top count is not a dark slot
    localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

    logic lit_next;

    // Duty compare: full duty forces on, zero duty never satisfies counter < duty
    always_comb begin
        lit_next = 1'b0;
        if (enable) begin
            if (duty == DUTY_FULL) begin
                lit_next = 1'b1;
            end else begin
                lit_next = (counter < duty);
            end
        end
    end

    // Register the lit state; this register is the LED output stage
    always_ff @(posedge clk) begin
        if (srst) begin
            lit <= 1'b0;
        end else begin
            lit <= lit_next;
        end
    end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel LED controller driven by a byte command stream. Provides
// per-channel enable, per-channel PWM duty (via 'L' <digit> <value>) and a
// global blink mode, with registered, polarity-configurable LED outputs.
// Cmd bytes carry the duty value, so PWM_BITS must not exceed 8.
module rgb_pwm_ctrl
    import rgb_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int PWM_BITS   = 8,
    parameter int BLINK_DIV  = 12_500_000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [7:0]        Cmd,
    input  logic              NewCmd,
    output logic [NUM_CH-1:0] LED,
    output logic [NUM_CH-1:0] Enables,
    output logic              BlinkOn,
    output logic              Busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW   = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [1:0]          state_reg;
    logic [CH_W-1:0]     ch_sel_reg;
    logic [NUM_CH-1:0]   enables_reg;
    logic                blink_on_reg;
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [BW-1:0]       blink_cnt_reg;
    logic                phase_reg;

    logic [7:0]          digit_off;
    logic                digit_valid;
    logic [NUM_CH-1:0]   toggle_mask;
    logic                idle_cmd;
    logic                duty_we;
    logic                blink_restart;
    logic                blink_gate;
    logic [NUM_CH-1:0]   lit_vec;

    // Command decode helpers; digit_off wraps for bytes below '0', so the
    // unsigned range check alone rejects them
    assign digit_off     = Cmd - CMD_DIGIT0;
    assign digit_valid   = (digit_off < 8'(NUM_CH));
    assign idle_cmd      = NewCmd && (state_reg == P_IDLE);
    assign duty_we       = NewCmd && (state_reg == P_VAL);
    assign blink_restart = idle_cmd && (Cmd == CMD_M);
    assign blink_gate    = ~blink_on_reg | phase_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_toggle
            // A channel toggles on its digit, or on its colour letter for 0..2
            assign toggle_mask[gi] = (digit_off == 8'(gi))
                                  || ((gi == 0) && (Cmd == CMD_R))
                                  || ((gi == 1) && (Cmd == CMD_G))
                                  || ((gi == 2) && (Cmd == CMD_B));
        end
    endgenerate

    // Parser FSM together with the enable and blink-mode registers it controls
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg    <= P_IDLE;
            ch_sel_reg   <= '0;
            enables_reg  <= '0;
            blink_on_reg <= 1'b0;
        end else if (NewCmd) begin
            case (state_reg)
                P_IDLE: begin
                    if (Cmd == CMD_K) begin
                        enables_reg <= '0;
                    end else if (Cmd == CMD_A) begin
                        enables_reg <= '1;
                    end else begin
                        enables_reg <= enables_reg ^ toggle_mask;
                    end
                    if (Cmd == CMD_M) begin
                        blink_on_reg <= ~blink_on_reg;
                    end
                    if (Cmd == CMD_L) begin
                        state_reg <= P_CH;
                    end
                end
                P_CH: begin
                    if (digit_valid) begin
                        ch_sel_reg <= digit_off[CH_W-1:0];
                        state_reg  <= P_VAL;
                    end else begin
                        state_reg  <= P_IDLE;
                    end
                end
                P_VAL: begin
                    state_reg <= P_IDLE;
                end
                default: begin
                    state_reg <= P_IDLE;
                end
            endcase
        end
    end

    // Free-running PWM counter shared by all channels
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
        end
    end

    // Blink prescaler and phase; restarted lit-first on every blink-mode change
    always_ff @(posedge Clock) begin
        if (Reset || blink_restart) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b1;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            phase_reg     <= ~phase_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [PWM_BITS-1:0] duty_reg;

            // Per-channel duty level, written by the value byte of an 'L' sequence
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    duty_reg <= '1;
                end else if (duty_we && (ch_sel_reg == CH_W'(gi))) begin
                    duty_reg <= Cmd[PWM_BITS-1:0];
                end
            end

            pwm_channel #(
                .PWM_BITS (PWM_BITS)
            ) u_pwm_channel (
                .clk     (Clock),
                .srst    (Reset),
                .counter (pwm_cnt_reg),
                .duty    (duty_reg),
                .enable  (enables_reg[gi] & blink_gate),
                .lit     (lit_vec[gi])
            );
        end
    endgenerate

    // Polarity is a constant inversion of the registered lit vector
    assign LED     = (ACTIVE_LOW != 0) ? ~lit_vec : lit_vec;
    assign Enables = enables_reg;
    assign BlinkOn = blink_on_reg;
    assign Busy    = (state_reg != P_IDLE);

endmodule
